// File: rtl/mem_port_arbiter_if.sv
// Bundle between the requester clients, the arbiter and the memory controller's mem_* port.
// slave is the arbiter's view; master is the clients-plus-memory environment.
interface mem_port_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int MEM_DEPTH  = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int AW = $clog2(MEM_DEPTH);

   logic [NUM_REQ*AW-1:0]         req_raddr;
   logic [NUM_REQ-1:0]            req_ren;
   logic [NUM_REQ-1:0]            req_rready;
   logic [DATA_WIDTH-1:0]         req_rdata;
   logic [NUM_REQ-1:0]            req_rdata_valid;
   logic [NUM_REQ*AW-1:0]         req_waddr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_wen;
   logic [NUM_REQ-1:0]            req_wready;
   logic [AW-1:0]                 mem_raddr;
   logic                          mem_ren;
   logic                          mem_rready;
   logic [DATA_WIDTH-1:0]         mem_rdata;
   logic                          mem_rdata_valid;
   logic [AW-1:0]                 mem_waddr;
   logic [DATA_WIDTH-1:0]         mem_wdata;
   logic                          mem_wen;
   logic                          mem_wready;

   modport slave (
      input  req_raddr, req_ren, req_waddr, req_wdata, req_wen,
             mem_rready, mem_rdata, mem_rdata_valid, mem_wready,
      output req_rready, req_rdata, req_rdata_valid, req_wready,
             mem_raddr, mem_ren, mem_waddr, mem_wdata, mem_wen
   );

   modport master (
      output req_raddr, req_ren, req_waddr, req_wdata, req_wen,
             mem_rready, mem_rdata, mem_rdata_valid, mem_wready,
      input  req_rready, req_rdata, req_rdata_valid, req_wready,
             mem_raddr, mem_ren, mem_waddr, mem_wdata, mem_wen
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the memory controller's read and write ports between NUM_REQ clients.
// Each direction has its own pointer and lock; read responses are steered back by rsp_id.
module mem_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int MEM_DEPTH  = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus,
   output logic [1:0]         debug_state
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [IW:0] NREQ_W = (IW+1)'(NUM_REQ);

   typedef enum logic {ARB_OPEN = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;

   // Handshake: a transfer happens in a cycle where mem_*en and mem_*ready are both high;
   // a granted request held against low ready stays locked until that cycle.
   arb_state_t    rd_state, rd_state_nxt, wr_state, wr_state_nxt;
   logic [IW-1:0] rd_ptr, rd_ptr_nxt, rd_lock_id, rd_lock_id_nxt, rsp_id, rsp_id_nxt;
   logic [IW-1:0] wr_ptr, wr_ptr_nxt, wr_lock_id, wr_lock_id_nxt;
   logic [IW-1:0] rd_gnt, wr_gnt, rd_idx, wr_idx;
   logic          rd_any, wr_any;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input logic [IW-1:0] off);
      logic [IW:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      return sum[IW-1:0];
   endfunction

   always_comb begin
      rd_gnt = rd_lock_id;
      rd_any = 1'b0;
      rd_idx = '0;
      wr_gnt = wr_lock_id;
      wr_any = 1'b0;
      wr_idx = '0;
      if (rd_state == ARB_LOCKED) begin
         rd_any = 1'b1;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            rd_idx = wrap_add(rd_ptr, IW'(k));
            if (!rd_any && bus.req_ren[rd_idx]) begin
               rd_any = 1'b1;
               rd_gnt = rd_idx;
            end
         end
      end
      if (wr_state == ARB_LOCKED) begin
         wr_any = 1'b1;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            wr_idx = wrap_add(wr_ptr, IW'(k));
            if (!wr_any && bus.req_wen[wr_idx]) begin
               wr_any = 1'b1;
               wr_gnt = wr_idx;
            end
         end
      end
   end

   // Outputs are forced to zero while rst is high even if clients keep requesting.
   always_comb begin
      bus.mem_ren         = rd_any && !rst;
      bus.mem_raddr       = '0;
      bus.req_rready      = '0;
      bus.req_rdata_valid = '0;
      bus.mem_wen         = wr_any && !rst;
      bus.mem_waddr       = '0;
      bus.mem_wdata       = '0;
      bus.req_wready      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!rst && rd_any && rd_gnt == IW'(i)) begin
            bus.mem_raddr     = bus.req_raddr[i*AW +: AW];
            bus.req_rready[i] = bus.mem_rready;
         end
         if (!rst && wr_any && wr_gnt == IW'(i)) begin
            bus.mem_waddr     = bus.req_waddr[i*AW +: AW];
            bus.mem_wdata     = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            bus.req_wready[i] = bus.mem_wready;
         end
         bus.req_rdata_valid[i] = !rst && bus.mem_rdata_valid && (rsp_id == IW'(i));
      end
   end

   assign bus.req_rdata = bus.mem_rdata;
   assign debug_state   = {wr_state == ARB_LOCKED, rd_state == ARB_LOCKED};

   always_comb begin
      rd_state_nxt   = rd_state;
      rd_ptr_nxt     = rd_ptr;
      rd_lock_id_nxt = rd_lock_id;
      rsp_id_nxt     = rsp_id;
      wr_state_nxt   = wr_state;
      wr_ptr_nxt     = wr_ptr;
      wr_lock_id_nxt = wr_lock_id;
      if (rd_any) begin
         if (bus.mem_rready) begin
            rd_state_nxt = ARB_OPEN;
            rd_ptr_nxt   = wrap_add(rd_gnt, IW'(1));
            rsp_id_nxt   = rd_gnt;
         end else begin
            rd_state_nxt   = ARB_LOCKED;
            rd_lock_id_nxt = rd_gnt;
         end
      end
      if (wr_any) begin
         if (bus.mem_wready) begin
            wr_state_nxt = ARB_OPEN;
            wr_ptr_nxt   = wrap_add(wr_gnt, IW'(1));
         end else begin
            wr_state_nxt   = ARB_LOCKED;
            wr_lock_id_nxt = wr_gnt;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state   <= ARB_OPEN;
         rd_ptr     <= '0;
         rd_lock_id <= '0;
         rsp_id     <= '0;
         wr_state   <= ARB_OPEN;
         wr_ptr     <= '0;
         wr_lock_id <= '0;
      end else begin
         rd_state   <= rd_state_nxt;
         rd_ptr     <= rd_ptr_nxt;
         rd_lock_id <= rd_lock_id_nxt;
         rsp_id     <= rsp_id_nxt;
         wr_state   <= wr_state_nxt;
         wr_ptr     <= wr_ptr_nxt;
         wr_lock_id <= wr_lock_id_nxt;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a one-cycle-latency memory model with write-to-read
// forwarding, and hand-computed grants, addresses and read data.
module tb_mem_port_arbiter;
   localparam int NUM_REQ = 4;
   localparam int MEM_DEPTH = 32;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    debug_state;
   int            n_vec = 0;
   int            n_err = 0;
   int            wr_count = 0;
   int            wc0;
   logic [DW-1:0] mem [MEM_DEPTH];
   logic [1:0]    gseq [5];

   mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(DW)) bus ();

   mem_port_arbiter #(.NUM_REQ(NUM_REQ), .MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .debug_state (debug_state)
   );

   always #5 clk = ~clk;

   // Memory model: word k preloads to 0xD000_0000+k, same-cycle write to the read address forwards.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.mem_rdata_valid <= 1'b0;
         bus.mem_rdata       <= '0;
         for (int k = 0; k < MEM_DEPTH; k++) mem[k] <= DW'(32'hD000_0000 + k);
      end else begin
         bus.mem_rdata_valid <= bus.mem_ren && bus.mem_rready;
         if (bus.mem_ren && bus.mem_rready)
            bus.mem_rdata <= (bus.mem_wen && bus.mem_wready && bus.mem_waddr == bus.mem_raddr)
                             ? bus.mem_wdata : mem[bus.mem_raddr];
         if (bus.mem_wen && bus.mem_wready) begin
            mem[bus.mem_waddr] <= bus.mem_wdata;
            wr_count           <= wr_count + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_reqs();
      bus.req_ren = '0;
      bus.req_wen = '0;
   endtask

   task automatic set_raddr(input int i, input logic [AW-1:0] a);
      bus.req_raddr[i*AW +: AW] = a;
   endtask

   task automatic set_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_waddr[i*AW +: AW] = a;
      bus.req_wdata[i*DW +: DW] = d;
   endtask

   initial begin
      gseq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      bus.req_raddr  = '0;
      bus.req_waddr  = '0;
      bus.req_wdata  = '0;
      clear_reqs();
      bus.mem_rready = 1'b1;
      bus.mem_wready = 1'b1;
      rst = 1'b1;
      repeat (2) tick();

      chk("reset_mem_ren", bus.mem_ren, 1'b0);
      chk("reset_rready", bus.req_rready, 4'b0000);
      chk("reset_rvalid", bus.req_rdata_valid, 4'b0000);
      chk("reset_state", debug_state, 2'b00);
      rst = 1'b0;

      // Round-robin over four continuous readers, addresses i+1
      for (int i = 0; i < NUM_REQ; i++) set_raddr(i, AW'(i + 1));
      bus.req_ren = 4'b1111;
      for (int s = 0; s < 5; s++) begin
         settle();
         chk("rr_rready", bus.req_rready, 4'b0001 << gseq[s]);
         chk("rr_raddr", bus.mem_raddr, 5'(gseq[s] + 1));
         tick();
         chk("rr_rvalid", bus.req_rdata_valid, 4'b0001 << gseq[s]);
         chk("rr_rdata", bus.req_rdata, 32'hD000_0001 + 32'(gseq[s]));
      end
      clear_reqs();

      // Single read from requester 2
      set_raddr(2, 5'd5);
      bus.req_ren = 4'b0100;
      settle();
      chk("single_ren", bus.mem_ren, 1'b1);
      chk("single_raddr", bus.mem_raddr, 5'd5);
      chk("single_rready", bus.req_rready, 4'b0100);
      tick();
      clear_reqs();
      chk("single_rvalid", bus.req_rdata_valid, 4'b0100);
      chk("single_rdata", bus.req_rdata, 32'hD000_0005);

      // Lock under read stall; write side keeps moving meanwhile
      set_raddr(2, 5'd9);
      set_raddr(0, 5'd3);
      set_write(0, 5'd20, 32'h1234_5678);
      bus.req_ren = 4'b0100;
      bus.req_wen = 4'b0001;
      bus.mem_rready = 1'b0;
      settle();
      chk("stall1_raddr", bus.mem_raddr, 5'd9);
      chk("stall1_rready", bus.req_rready, 4'b0000);
      chk("stall1_wready", bus.req_wready, 4'b0001);
      tick();
      bus.req_wen = 4'b0000;
      chk("stall_state", debug_state, 2'b01);
      bus.req_ren = 4'b0101;
      settle();
      chk("stall2_raddr", bus.mem_raddr, 5'd9);
      chk("stall2_rready", bus.req_rready, 4'b0000);
      tick();
      settle();
      chk("stall3_raddr", bus.mem_raddr, 5'd9);
      tick();
      bus.mem_rready = 1'b1;
      settle();
      chk("stall_release_rready", bus.req_rready, 4'b0100);
      chk("stall_release_raddr", bus.mem_raddr, 5'd9);
      tick();
      bus.req_ren = 4'b0001;
      chk("stall_rvalid2", bus.req_rdata_valid, 4'b0100);
      chk("stall_rdata2", bus.req_rdata, 32'hD000_0009);
      settle();
      chk("after_lock_rready", bus.req_rready, 4'b0001);
      chk("after_lock_raddr", bus.mem_raddr, 5'd3);
      tick();
      clear_reqs();
      chk("after_lock_rvalid", bus.req_rdata_valid, 4'b0001);
      chk("after_lock_rdata", bus.req_rdata, 32'hD000_0003);
      chk("after_lock_state", debug_state, 2'b00);

      // Concurrent write (req 1) and read (req 3) of address 7
      set_write(1, 5'd7, 32'hA5A5_A5A5);
      set_raddr(3, 5'd7);
      bus.req_wen = 4'b0010;
      bus.req_ren = 4'b1000;
      settle();
      chk("conc_wready", bus.req_wready, 4'b0010);
      chk("conc_rready", bus.req_rready, 4'b1000);
      chk("conc_waddr", bus.mem_waddr, 5'd7);
      chk("conc_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
      chk("conc_raddr", bus.mem_raddr, 5'd7);
      tick();
      clear_reqs();
      chk("conc_rvalid", bus.req_rdata_valid, 4'b1000);
      chk("conc_rdata", bus.req_rdata, 32'hA5A5_A5A5);

      // Write back-pressure: wr_ptr is 2, so requester 0 wins and is locked
      wc0 = wr_count;
      set_write(0, 5'd10, 32'h1111_0000);
      set_write(1, 5'd11, 32'h2222_1111);
      bus.req_wen = 4'b0011;
      bus.mem_wready = 1'b0;
      settle();
      chk("wbp1_wen", bus.mem_wen, 1'b1);
      chk("wbp1_waddr", bus.mem_waddr, 5'd10);
      chk("wbp1_wready", bus.req_wready, 4'b0000);
      tick();
      settle();
      chk("wbp_state", debug_state, 2'b10);
      chk("wbp2_waddr", bus.mem_waddr, 5'd10);
      tick();
      bus.mem_wready = 1'b1;
      settle();
      chk("wbp3_wready", bus.req_wready, 4'b0001);
      chk("wbp3_wdata", bus.mem_wdata, 32'h1111_0000);
      tick();
      bus.req_wen = 4'b0010;
      settle();
      chk("wbp4_wready", bus.req_wready, 4'b0010);
      chk("wbp4_waddr", bus.mem_waddr, 5'd11);
      chk("wbp4_wdata", bus.mem_wdata, 32'h2222_1111);
      tick();
      clear_reqs();
      settle();
      chk("wbp_mem10", mem[10], 32'h1111_0000);
      chk("wbp_mem11", mem[11], 32'h2222_1111);
      chk("wbp_count", 64'(wr_count - wc0), 64'd2);
      chk("stall_side_mem20", mem[20], 32'h1234_5678);
      chk("conc_mem7", mem[7], 32'hA5A5_A5A5);

      // Reset while a read lock is held on requester 3
      set_raddr(3, 5'd4);
      set_raddr(0, 5'd3);
      bus.req_ren = 4'b1000;
      bus.mem_rready = 1'b0;
      tick();
      chk("rst_lock_state", debug_state, 2'b01);
      bus.req_ren = 4'b1001;
      bus.req_wen = 4'b0011;
      rst = 1'b1;
      settle();
      chk("rst_mem_ren", bus.mem_ren, 1'b0);
      chk("rst_mem_wen", bus.mem_wen, 1'b0);
      chk("rst_rready", bus.req_rready, 4'b0000);
      chk("rst_wready", bus.req_wready, 4'b0000);
      chk("rst_raddr", bus.mem_raddr, 5'd0);
      chk("rst_waddr", bus.mem_waddr, 5'd0);
      chk("rst_wdata", bus.mem_wdata, 32'h0);
      chk("rst_rvalid", bus.req_rdata_valid, 4'b0000);
      chk("rst_state", debug_state, 2'b00);
      tick();
      rst = 1'b0;
      bus.req_wen = 4'b0000;
      bus.mem_rready = 1'b1;
      settle();
      chk("post_rst_rready", bus.req_rready, 4'b0001);
      chk("post_rst_raddr", bus.mem_raddr, 5'd3);
      tick();
      bus.req_ren = 4'b1000;
      chk("post_rst_rvalid0", bus.req_rdata_valid, 4'b0001);
      settle();
      chk("post_rst_rready3", bus.req_rready, 4'b1000);
      chk("post_rst_raddr3", bus.mem_raddr, 5'd4);
      tick();
      clear_reqs();
      chk("post_rst_rvalid3", bus.req_rdata_valid, 4'b1000);
      chk("post_rst_rdata3", bus.req_rdata, 32'hD000_0004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the cache-side read and write ports of the memory controller between NUM_REQ requesters. Each direction (read, write) is arbitrated independently. A grant issued while the memory port is back-pressured is locked until it handshakes. Read responses, which return one cycle after the read handshake, are steered back to the requester that issued them. The block sits between the cache lookup/hit-path clients and the memory controller's `mem_*` port; the refill (`fetch_*`) port is not routed through it.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- MEM_DEPTH, 32, memory depth; AW = $clog2(MEM_DEPTH)
- DATA_WIDTH, 32, data width; IW = $clog2(NUM_REQ)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_raddr  in  NUM_REQ*AW  read addresses, requester i at [i*AW +: AW]
- req_ren  in  NUM_REQ  read requests
- req_rready  out  NUM_REQ  read accepted (one-hot or zero)
- req_rdata  out  DATA_WIDTH  read data, shared by all requesters
- req_rdata_valid  out  NUM_REQ  read data valid, one-hot or zero
- req_waddr  in  NUM_REQ*AW  write addresses
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data
- req_wen  in  NUM_REQ  write requests
- req_wready  out  NUM_REQ  write accepted
- mem_raddr / mem_ren  out  AW / 1  downstream read request
- mem_rready  in  1  downstream read ready
- mem_rdata / mem_rdata_valid  in  DATA_WIDTH / 1  downstream read response, one cycle after the read handshake
- mem_waddr / mem_wdata / mem_wen  out  AW / DATA_WIDTH / 1  downstream write request
- mem_wready  in  1  downstream write ready

## Operation
- Requester rule: once req_ren[i] or req_wen[i] is asserted, the requester holds it and its address/data stable until the matching ready. Dropping a request early is illegal.
- Read arbiter state:
  - rd_ptr (IW bits): highest-priority requester.
  - rd_lock_vld, rd_lock_id: locked grant.
- Read grant, combinational:
  - If rd_lock_vld, grant = rd_lock_id.
  - Else grant = first i with req_ren[i], scanning rd_ptr, rd_ptr+1, … with wrap modulo NUM_REQ.
- Read outputs:
  - mem_ren = any request granted.
  - mem_raddr = granted requester's address; 0 when idle.
  - req_rready[g] = mem_rready for the granted g only; all other bits are 0.
- Read handshake (mem_ren && mem_rready):
  - rd_ptr ← (g+1) mod NUM_REQ; for non-power-of-2 NUM_REQ, wrap explicitly.
  - rd_lock_vld ← 0.
  - rsp_id ← g.
- Read stall (mem_ren && !mem_rready): rd_lock_vld ← 1, rd_lock_id ← g.
  - Requests arriving later, even from a higher-priority requester, do not preempt the lock.
- Read response:
  - req_rdata = mem_rdata, passed straight through.
  - req_rdata_valid[i] = mem_rdata_valid && (rsp_id == i).
  - One read outstanding at a time downstream, so a single rsp_id register suffices.
- Write arbiter: identical structure with wr_ptr, wr_lock_vld, wr_lock_id, mem_wready.
  - No response path.
  - mem_wdata = granted requester's data.
- Read and write may handshake in the same cycle, for the same or different requesters.
- Same-cycle same-address read/write ordering and bypass are handled by the memory controller, not here.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 handshakes of its own direction.

## Timing
- Grant, mem_* request outputs and req_*ready outputs are combinational from requests, state and mem_*ready. There are no added cycles.
- Read data reaches the requester one cycle after its req_rready handshake (the memory latency, passed through).
- Pointer and lock updates take effect the cycle after the handshake or stall.
- Reset values:
  - rd_ptr = wr_ptr = 0.
  - Both locks clear.
  - rsp_id = 0.
  - While rst is high: req_rready = req_wready = 0, req_rdata_valid = 0, mem_ren = mem_wen = 0, mem addresses/data = 0.
- Reset mid-stall: the lock is dropped and arbitration restarts from requester 0 on the first cycle after rst deasserts.
- Reset with a read response in flight: the response is discarded. The memory controller resets its valid at the same time.
- mem_rready held low indefinitely: the locked grant is held; the write side is unaffected.

## Test plan
- Single read: req_ren=0b0100, raddr[2]=5, mem_rready=1 → mem_raddr=5, req_rready=0b0100 the same cycle; next cycle req_rdata_valid=0b0100 with mem[5].
- Round-robin: all four req_ren held high, mem_rready=1 → grant order 0,1,2,3,0 on consecutive cycles; each req_rdata_valid bit one cycle after its grant.
- Lock under stall:
  - Stimulus: requester 2 granted with mem_rready=0 for 3 cycles; requester 0 raises req_ren in cycle 2.
  - Required response: grant stays at 2 with constant mem_raddr; requester 2 handshakes when mem_rready=1; requester 0 is granted next.
- Concurrent read/write: req_wen=0b0010 (addr 7, data 0xA5A5A5A5) and req_ren=0b1000 (addr 7) in the same cycle, both ready → both handshake the same cycle; requester 3 receives 0xA5A5A5A5 next cycle.
- Write back-pressure: mem_wready=0 for 2 cycles with req_wen=0b0011 → requester 0 locked; order 0 then 1; no write lost or duplicated (check the memory model).
- Reset mid-stall: rst asserted while a read lock is held on requester 3 → all outputs 0 during reset; after release, with req_ren=0b1001, requester 0 is granted first.
